ieee_float_to_int: RTL and testbench



---
 rtl/ieee_float_to_int.sv | 152 +++++++++++++++
 tb/tb_ieee_float_to_int.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ieee_float_to_int.sv
// IEEE-754 single-precision to signed 32-bit integer converter.
// Iterative 1-bit-per-cycle alignment, RNE or truncate rounding, valid/ready on both sides.
module ieee_float_to_int #(
  parameter int ROUND_MODE = 0,
  parameter int SHIFT_CAP  = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_number,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_int,
  output logic        out_invalid,
  output logic        out_inexact
);

  // state | meaning
  // IDLE  | waiting for an input word, in_ready high
  // SHIFT | aligning the significand one bit per cycle
  // ROUND | phase 0 rounds the magnitude, phase 1 applies the sign
  // DONE  | result presented, held until out_ready
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [8:0] CAP = 9'(SHIFT_CAP);
  localparam logic       RNE = (ROUND_MODE == 0);

  logic [1:0]  state;
  logic [56:0] w;
  logic [8:0]  cnt;
  logic        sgn;
  logic        left;
  logic        rnd_phase;
  logic [31:0] mag;

  logic [7:0]  exp_f;
  logic [22:0] frac;
  logic [23:0] sig;
  logic [8:0]  e_unb;
  logic [8:0]  e_neg;
  logic [8:0]  n_load;
  logic        too_big;
  logic [31:0] sat_val;
  logic        g_bit;
  logic        st_bit;
  logic [31:0] m_cur;
  logic        inc;

  always_comb begin
    exp_f   = in_number[30:23];
    frac    = in_number[22:0];
    sig     = {|exp_f, frac};
    e_unb   = {1'b0, exp_f} - 9'd127;
    e_neg   = 9'd0 - e_unb;
    n_load  = e_unb;
    if (e_unb[8]) begin
      n_load = (e_neg > CAP) ? CAP : e_neg;
    end
    too_big = !e_unb[8] && (e_unb >= 9'd31);
    sat_val = in_number[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    g_bit   = w[24];
    st_bit  = |w[23:0];
    m_cur   = w[56:25];
    inc     = RNE & g_bit & (st_bit | m_cur[0]);
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      w           <= '0;
      cnt         <= '0;
      sgn         <= 1'b0;
      left        <= 1'b0;
      rnd_phase   <= 1'b0;
      mag         <= '0;
      out_int     <= '0;
      out_invalid <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sgn         <= in_number[31];
            left        <= ~e_unb[8];
            w           <= {31'b0, sig, 2'b0};
            cnt         <= n_load;
            rnd_phase   <= 1'b0;
            out_int     <= '0;
            out_invalid <= 1'b0;
            out_inexact <= 1'b0;
            if (exp_f == 8'hFF) begin
              state       <= DONE;
              out_invalid <= 1'b1;
              out_int     <= (frac != 23'd0) ? 32'h8000_0000 : sat_val;
            end else if (exp_f == 8'h00) begin
              state       <= DONE;
              out_inexact <= |frac;
            end else if (too_big) begin
              state <= DONE;
              // -2^31 is the one representable value at E = 31
              if (in_number == 32'hCF00_0000) begin
                out_int <= 32'h8000_0000;
              end else begin
                out_int     <= sat_val;
                out_invalid <= 1'b1;
              end
            end else begin
              state <= (n_load != 9'd0) ? SHIFT : ROUND;
            end
          end
        end
        SHIFT: begin
          if (left) begin
            w <= {w[55:0], 1'b0};
          end else begin
            w <= {1'b0, w[56:2], w[1] | w[0]};
          end
          cnt <= cnt - 9'd1;
          if (cnt == 9'd1) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          // Increment and negate are split over two cycles to keep the carry chains apart
          if (!rnd_phase) begin
            mag         <= m_cur + {31'b0, inc};
            out_inexact <= g_bit | st_bit;
            rnd_phase   <= 1'b1;
          end else begin
            out_int   <= sgn ? (32'd0 - mag) : mag;
            rnd_phase <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ieee_float_to_int.sv
// Directed bench for ieee_float_to_int: RNE and truncating instances driven in lockstep.
module tb_ieee_float_to_int;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_number;
  logic        out_ready;
  logic        in_ready,    tr_in_ready;
  logic        out_valid,   tr_out_valid;
  logic [31:0] out_int,     tr_out_int;
  logic        out_invalid, tr_out_invalid;
  logic        out_inexact, tr_out_inexact;

  int vecs = 0;
  int miss = 0;

  ieee_float_to_int #(.ROUND_MODE(0), .SHIFT_CAP(26)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_number(in_number),
    .out_valid(out_valid), .out_ready(out_ready), .out_int(out_int),
    .out_invalid(out_invalid), .out_inexact(out_inexact)
  );

  ieee_float_to_int #(.ROUND_MODE(1), .SHIFT_CAP(26)) u_tr (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(tr_in_ready), .in_number(in_number),
    .out_valid(tr_out_valid), .out_ready(out_ready), .out_int(tr_out_int),
    .out_invalid(tr_out_invalid), .out_inexact(tr_out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Submit one word, measure latency from the accept edge, hold out_ready low for
  // 'hold' cycles while checking stability, then complete the handshake.
  task automatic conv(input string tag, input logic [31:0] num, input int exp_lat,
                      input logic [31:0] exp_int, input logic [31:0] exp_tr,
                      input logic exp_inv, input logic exp_inx, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    in_number = num;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".int"}, out_int, exp_int);
    chk({tag, ".tr_int"}, tr_out_int, exp_tr);
    chk({tag, ".inv"}, {31'b0, out_invalid}, {31'b0, exp_inv});
    chk({tag, ".inx"}, {31'b0, out_inexact}, {31'b0, exp_inx});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, ".hold_int"}, out_int, exp_int);
      chk({tag, ".hold_in_ready"}, {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, ".post_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, ".post_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_number = '0;
    out_ready = 1'b0;
    #12;
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.out_int", out_int, 32'd0);
    chk("rst.flags", {30'b0, out_invalid, out_inexact}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //   tag        word           lat  rne_int        trunc_int      inv   inx   hold
    conv("one",     32'h3F80_0000, 2,   32'd1,         32'd1,         1'b0, 1'b0, 0);
    conv("2p5",     32'h4020_0000, 3,   32'd2,         32'd2,         1'b0, 1'b1, 0);
    conv("3p5",     32'h4060_0000, 3,   32'd4,         32'd3,         1'b0, 1'b1, 0);
    conv("m1p5",    32'hBFC0_0000, 2,   32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);
    conv("half",    32'h3F00_0000, 3,   32'd0,         32'd0,         1'b0, 1'b1, 0);
    conv("half_up", 32'h3F00_0001, 3,   32'd1,         32'd0,         1'b0, 1'b1, 0);
    conv("min_int", 32'hCF00_0000, 1,   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0);
    conv("pos_ovf", 32'h4F00_0000, 1,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 0);
    conv("nan",     32'h7FC0_0000, 1,   32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 0);
    conv("neg_inf", 32'hFF80_0000, 1,   32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 0);
    conv("denorm",  32'h0000_0001, 1,   32'd0,         32'd0,         1'b0, 1'b1, 0);
    conv("bp_max",  32'h4EFF_FFFF, 32,  32'h7FFF_FF80, 32'h7FFF_FF80, 1'b0, 1'b0, 3);

    // Reset in the middle of a long SHIFT phase
    @(negedge clk);
    in_number = 32'h4E80_0000;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort.out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort.in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort.out_int", out_int, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    conv("after_rst", 32'h42F6_0000, 8, 32'd123, 32'd123, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
